// File: rtl/mc_pkg.sv
// Shared constants and types for the multicycle MIPS control FSM.
// Opcodes, function codes, state encoding, ALU ops and mux-select values.
package mc_pkg;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpJal   = 6'h03;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    localparam logic [5:0] FnJr  = 6'h08;
    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnAnd = 6'h24;
    localparam logic [5:0] FnOr  = 6'h25;
    localparam logic [5:0] FnSlt = 6'h2A;

    typedef enum logic [3:0] {
        StFetch   = 4'd0,  StDecode  = 4'd1,  StExecR = 4'd2,  StWbR    = 4'd3,
        StExecI   = 4'd4,  StWbI     = 4'd5,  StAddr  = 4'd6,  StMemRd  = 4'd7,
        StWbMem   = 4'd8,  StMemWr   = 4'd9,  StBranch = 4'd10, StJump  = 4'd11,
        StJr      = 4'd12, StJalWb   = 4'd13, StHalt  = 4'd14, StIllegal = 4'd15
    } state_e;

    typedef enum logic [2:0] {
        AluAdd = 3'd0, AluSub = 3'd1, AluAnd = 3'd2, AluOr = 3'd3, AluSlt = 3'd4
    } alu_op_e;

    typedef enum logic [3:0] {
        ClsR, ClsJr, ClsLw, ClsSw, ClsAddi, ClsBeq, ClsBne, ClsJ, ClsJal, ClsIllegal
    } inst_class_e;

    localparam logic [1:0] PcSrcAlu    = 2'd0;
    localparam logic [1:0] PcSrcAluOut = 2'd1;
    localparam logic [1:0] PcSrcJump   = 2'd2;
    localparam logic [1:0] PcSrcRs     = 2'd3;

    localparam logic [1:0] AluBRt      = 2'd0;
    localparam logic [1:0] AluBFour    = 2'd1;
    localparam logic [1:0] AluBImm     = 2'd2;
    localparam logic [1:0] AluBImmSh2  = 2'd3;

    localparam logic [1:0] RfDstRt  = 2'd0;
    localparam logic [1:0] RfDstRd  = 2'd1;
    localparam logic [1:0] RfDstR31 = 2'd2;

    localparam logic [1:0] RfSrcAluOut = 2'd0;
    localparam logic [1:0] RfSrcMdr    = 2'd1;
    localparam logic [1:0] RfSrcPc     = 2'd2;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: inst -> class, R-type ALU op, legality.
// An all-zero word decodes as sll $0,$0,0 (a legal nop); halting on it is the FSM's choice.
module mc_decode
    import mc_pkg::*;
(
    input  logic [31:0]  inst,
    output inst_class_e  cls,
    output alu_op_e      alu_op,
    output logic         legal
);

    always_comb begin
        cls    = ClsIllegal;
        alu_op = AluAdd;
        unique case (inst[31:26])
            OpRtype: begin
                unique case (inst[5:0])
                    FnJr:  cls = ClsJr;
                    FnAdd: begin cls = ClsR; alu_op = AluAdd; end
                    FnSub: begin cls = ClsR; alu_op = AluSub; end
                    FnAnd: begin cls = ClsR; alu_op = AluAnd; end
                    FnOr:  begin cls = ClsR; alu_op = AluOr;  end
                    FnSlt: begin cls = ClsR; alu_op = AluSlt; end
                    default: cls = (inst == '0) ? ClsR : ClsIllegal;
                endcase
            end
            OpLw:    cls = ClsLw;
            OpSw:    cls = ClsSw;
            OpAddi:  cls = ClsAddi;
            OpBeq:   cls = ClsBeq;
            OpBne:   cls = ClsBne;
            OpJ:     cls = ClsJ;
            OpJal:   cls = ClsJal;
            default: cls = ClsIllegal;
        endcase
    end

    assign legal = (cls != ClsIllegal);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences PC/IR/regfile/ALU/memory over several cycles,
// with a variable-latency memory handshake and sticky halt/illegal flags.
module multicycle_ctrl
    import mc_pkg::*;
#(
    parameter bit          HALT_ON_ZERO = 1'b1,
    parameter int unsigned STATE_W      = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        inst,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_write,
    output logic               addr_src,
    output logic               ir_en,
    output logic               pc_en,
    output logic [1:0]         pc_src,
    output logic               alu_a_src,
    output logic [1:0]         alu_b_src,
    output logic [2:0]         alu_op,
    output logic               rf_we,
    output logic [1:0]         rf_dst,
    output logic [1:0]         rf_src,
    output logic               halted,
    output logic               illegal,
    output logic [STATE_W-1:0] state_o
);

    state_e      state_q;
    logic        halted_q, illegal_q;
    inst_class_e cls;
    alu_op_e     dec_alu_op;
    logic        legal;

    mc_decode u_decode (
        .inst   (inst),
        .cls    (cls),
        .alu_op (dec_alu_op),
        .legal  (legal)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StFetch;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                StFetch:  if (mem_ready) state_q <= StDecode;
                StDecode: begin
                    if (HALT_ON_ZERO && inst == '0) begin
                        state_q  <= StHalt;
                        halted_q <= 1'b1;
                    end else if (!legal) begin
                        state_q   <= StIllegal;
                        halted_q  <= 1'b1;
                        illegal_q <= 1'b1;
                    end else begin
                        unique case (cls)
                            ClsR:          state_q <= StExecR;
                            ClsJr:         state_q <= StJr;
                            ClsLw, ClsSw:  state_q <= StAddr;
                            ClsAddi:       state_q <= StExecI;
                            ClsBeq, ClsBne: state_q <= StBranch;
                            ClsJ:          state_q <= StJump;
                            ClsJal:        state_q <= StJalWb;
                            default:       state_q <= StIllegal;
                        endcase
                    end
                end
                StExecR:  state_q <= StWbR;
                StExecI:  state_q <= StWbI;
                StAddr:   state_q <= (cls == ClsSw) ? StMemWr : StMemRd;
                StMemRd:  if (mem_ready) state_q <= StWbMem;
                StMemWr:  if (mem_ready) state_q <= StFetch;
                StWbR, StWbI, StWbMem, StBranch, StJump, StJr, StJalWb: state_q <= StFetch;
                default:  state_q <= state_q;
            endcase
        end
    end

    // Gating on reset makes mem_req drop asynchronously when a request is abandoned.
    always_comb begin
        mem_req   = 1'b0;
        mem_write = 1'b0;
        addr_src  = 1'b0;
        ir_en     = 1'b0;
        pc_en     = 1'b0;
        pc_src    = PcSrcAlu;
        alu_a_src = 1'b0;
        alu_b_src = AluBRt;
        alu_op    = AluAdd;
        rf_we     = 1'b0;
        rf_dst    = RfDstRt;
        rf_src    = RfSrcAluOut;
        if (reset) begin
            case (state_q)
                StFetch: begin
                    mem_req   = 1'b1;
                    alu_b_src = AluBFour;
                    if (mem_ready) begin
                        ir_en = 1'b1;
                        pc_en = 1'b1;
                    end
                end
                StDecode: alu_b_src = AluBImmSh2;
                StExecR: begin
                    alu_a_src = 1'b1;
                    alu_op    = dec_alu_op;
                end
                StWbR: begin
                    rf_we  = 1'b1;
                    rf_dst = RfDstRd;
                end
                StExecI, StAddr: begin
                    alu_a_src = 1'b1;
                    alu_b_src = AluBImm;
                end
                StWbI: rf_we = 1'b1;
                StMemRd: begin
                    mem_req  = 1'b1;
                    addr_src = 1'b1;
                end
                StWbMem: begin
                    rf_we  = 1'b1;
                    rf_src = RfSrcMdr;
                end
                StMemWr: begin
                    mem_req   = 1'b1;
                    mem_write = 1'b1;
                    addr_src  = 1'b1;
                end
                StBranch: begin
                    alu_a_src = 1'b1;
                    alu_op    = AluSub;
                    pc_src    = PcSrcAluOut;
                    pc_en     = (cls == ClsBne) ? !zero : zero;
                end
                StJump: begin
                    pc_en  = 1'b1;
                    pc_src = PcSrcJump;
                end
                StJr: begin
                    pc_en  = 1'b1;
                    pc_src = PcSrcRs;
                end
                StJalWb: begin
                    rf_we  = 1'b1;
                    rf_dst = RfDstR31;
                    rf_src = RfSrcPc;
                    pc_en  = 1'b1;
                    pc_src = PcSrcJump;
                end
                default: ;
            endcase
        end
    end

    assign halted  = halted_q;
    assign illegal = illegal_q;
    assign state_o = STATE_W'(state_q);

endmodule
